trk_accum_dump: RTL and testbench

- Per-channel correlator that consumes the carrier NCO outputs, code chips and timing strobes from the tracking clock generator.
- Integrates 2-bit IF samples into six I/Q early/prompt/late accumulators.
- Snapshots the accumulators into dump registers on the latch strobe and clears them on the clear strobe.
- Dumps go to the discriminator/loop-filter software through a valid/ack handshake.

---
 rtl/trk_pkg.sv | 18 +
 rtl/trk_accum_dump_if.sv | 7 +
 rtl/trk_strobe_sync.sv | 19 +
 rtl/trk_accum_dump.sv | 101 ++++++++++
 tb/tb_trk_accum_dump.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/trk_pkg.sv
// trk_pkg: shared types, sample/carrier decode helpers and constants for the tracking correlator.
package trk_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, RUN = 2'd2} trk_state_t;
    typedef struct packed {logic sign; logic [1:0] mag;} sm3_t;
    localparam logic [2:0] IF_MAG_LO = 3'd1;
    localparam logic [2:0] IF_MAG_HI = 3'd3;
    localparam logic [4:0] EPOCH_MOD = 5'd20;
    function automatic logic signed [4:0] if_decode(input logic [1:0] s);
        logic signed [4:0] m;
        m = signed'({2'b00, s[0] ? IF_MAG_HI : IF_MAG_LO});
        return s[1] ? -m : m;
    endfunction
    function automatic logic signed [4:0] sm_decode(input sm3_t x);
        logic signed [4:0] m;
        m = signed'({3'b000, x.mag});
        return x.sign ? -m : m;
    endfunction
endpackage

// File: rtl/trk_accum_dump_if.sv
// trk_accum_dump_if: dump snapshot bus with valid/ack handshake toward the loop-filter software.
interface trk_accum_dump_if #(parameter int ACC_W = 20);
    logic dump_valid, dump_ack;
    logic signed [ACC_W-1:0] dump_ie, dump_ip, dump_il, dump_qe, dump_qp, dump_ql;
    modport master (output dump_valid, dump_ie, dump_ip, dump_il, dump_qe, dump_qp, dump_ql, input dump_ack);
    modport slave (input dump_valid, dump_ie, dump_ip, dump_il, dump_qe, dump_qp, dump_ql, output dump_ack);
endinterface

// File: rtl/trk_strobe_sync.sv
// trk_strobe_sync: SYNC_STAGES synchroniser followed by a rising-edge detector (one-mclk pulse).
module trk_strobe_sync #(parameter int SYNC_STAGES = 2) (
    input  logic mclk,
    input  logic mclr,
    input  logic strobe,
    output logic pulse
);
    logic [SYNC_STAGES-1:0] sync;
    logic prev;
    always_ff @(posedge mclk or negedge mclr)
        if (!mclr) begin
            sync <= '0;
            prev <= 1'b0;
        end else begin
            sync <= (sync << 1) | SYNC_STAGES'(strobe);
            prev <= sync[SYNC_STAGES-1];
        end
    assign pulse = sync[SYNC_STAGES-1] & ~prev;
endmodule

// File: rtl/trk_accum_dump.sv
// trk_accum_dump: per-channel early/prompt/late I/Q correlator with latch/clear strobes and dump handshake.
// Define TRK_ACC_SAT_EN to saturate the accumulators; otherwise they wrap modulo 2^ACC_W.
module trk_accum_dump
    import trk_pkg::*;
#(
    parameter int ACC_W = 20,
    parameter int SYNC_STAGES = 2
) (
    input  logic mclk,
    input  logic mclr,
    input  logic [1:0] if_sample,
    input  logic [2:0] carr_sin,
    input  logic [2:0] carr_cos,
    input  logic code_e,
    input  logic code_p,
    input  logic code_l,
    input  logic enable,
    input  logic sel_20ms,
    input  logic len_1ms, aen_1ms, epo_1ms, clr_1ms,
    input  logic len_20ms, aen_20ms, epo_20ms, clr_20ms,
    trk_accum_dump_if.master dump,
    output logic [4:0] epoch_cnt,
    output logic overrun,
    output logic run
);
    logic [3:0] raw, pulse;
    logic len, aen, epo, clr, active, latch, valid;
    logic [5:0] code;
    trk_state_t state, nxt;
    logic signed [4:0] s, prod_i, prod_q;
    logic signed [4:0] term [6];
    logic signed [ACC_W-1:0] acc [6], sum [6], dmp [6];

    function automatic logic signed [ACC_W-1:0] add_acc(input logic signed [ACC_W-1:0] a, input logic signed [4:0] t);
        logic signed [ACC_W:0] w;
        w = {a[ACC_W-1], a} + {{(ACC_W-4){t[4]}}, t};
`ifdef TRK_ACC_SAT_EN
        if (w[ACC_W] != w[ACC_W-1]) return {w[ACC_W], {(ACC_W-1){~w[ACC_W]}}};
`endif
        return w[ACC_W-1:0];
    endfunction

    // strobe set is chosen before synchronisation so only one set ever reaches the edge detectors
    assign raw = sel_20ms ? {len_20ms, aen_20ms, epo_20ms, clr_20ms} : {len_1ms, aen_1ms, epo_1ms, clr_1ms};
    for (genvar g = 0; g < 4; g++) begin : g_sync
        trk_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (.mclk(mclk), .mclr(mclr), .strobe(raw[g]), .pulse(pulse[g]));
    end
    assign {len, aen, epo, clr} = pulse;

    assign s = if_decode(if_sample);
    assign prod_i = s * sm_decode(carr_cos);
    assign prod_q = s * sm_decode(carr_sin);
    assign code = {code_l, code_p, code_e, code_l, code_p, code_e};

    always_comb begin
        for (int k = 0; k < 6; k++) begin
            term[k] = (k < 3) ? (code[k] ? prod_i : -prod_i) : (code[k] ? prod_q : -prod_q);
            sum[k] = add_acc(acc[k], term[k]);
        end
    end

    always_ff @(posedge mclk or negedge mclr)
        if (!mclr) state <= IDLE;
        else state <= nxt;

    always_comb begin
        nxt = !enable ? IDLE : (state == IDLE) ? ARMED : (state == ARMED && aen) ? RUN : state;
    end

    always_comb begin
        run = state == RUN;
        active = run && enable;
        latch = active && len;
    end

    // dump takes the sum including this cycle's product; clr restarts from that product
    always_ff @(posedge mclk or negedge mclr)
        if (!mclr) begin
            acc <= '{default: '0};
            dmp <= '{default: '0};
            valid <= 1'b0;
            overrun <= 1'b0;
            epoch_cnt <= '0;
        end else begin
            for (int k = 0; k < 6; k++) begin
                acc[k] <= !active ? '0 : clr ? ACC_W'(term[k]) : sum[k];
                if (latch) dmp[k] <= sum[k];
            end
            valid <= latch | (valid & ~dump.dump_ack);
            overrun <= enable & (overrun | (latch & valid & ~dump.dump_ack));
            epoch_cnt <= (nxt == IDLE) ? '0 : !epo ? epoch_cnt : (epoch_cnt == EPOCH_MOD - 5'd1) ? '0 : epoch_cnt + 5'd1;
        end

    assign dump.dump_valid = valid;
    assign dump.dump_ie = dmp[0];
    assign dump.dump_ip = dmp[1];
    assign dump.dump_il = dmp[2];
    assign dump.dump_qe = dmp[3];
    assign dump.dump_qp = dmp[4];
    assign dump.dump_ql = dmp[5];
endmodule

// File: tb/tb_trk_accum_dump.sv
// tb_trk_accum_dump: directed and randomized checks of two correlators (ACC_W 20 and 8) against a behavioural model.
`timescale 1ns/1ps
module tb_trk_accum_dump;
    localparam int SYNC = 2;
    localparam int M_IDLE = 0, M_ARMED = 1, M_RUN = 2;
`ifdef TRK_ACC_SAT_EN
    localparam int OVF8 = 127;
`else
    localparam int OVF8 = 180 - 256;
`endif
    logic mclk = 0, mclr = 0, ack = 0;
    logic [1:0] if_sample;
    logic [2:0] carr_sin, carr_cos;
    logic code_e, code_p, code_l, enable, sel_20ms;
    logic len_1ms, aen_1ms, epo_1ms, clr_1ms, len_20ms, aen_20ms, epo_20ms, clr_20ms;
    logic [4:0] epoch_cnt, epoch8;
    logic overrun, run, overrun8, run8;
    logic signed [31:0] d [2][6];
    int checks = 0, failures = 0;
    int wid [2] = '{20, 8};
    int m_acc [2][6], m_dump [2][6];
    int m_epoch, m_mode;
    bit m_valid, m_over;
    bit hist [4][SYNC+2];

    trk_accum_dump_if #(.ACC_W(20)) bus ();
    trk_accum_dump_if #(.ACC_W(8)) bus8 ();
    assign bus.dump_ack = ack;
    assign bus8.dump_ack = ack;

    trk_accum_dump #(.ACC_W(20), .SYNC_STAGES(SYNC)) dut (
        .mclk(mclk), .mclr(mclr), .if_sample(if_sample), .carr_sin(carr_sin), .carr_cos(carr_cos),
        .code_e(code_e), .code_p(code_p), .code_l(code_l), .enable(enable), .sel_20ms(sel_20ms),
        .len_1ms(len_1ms), .aen_1ms(aen_1ms), .epo_1ms(epo_1ms), .clr_1ms(clr_1ms),
        .len_20ms(len_20ms), .aen_20ms(aen_20ms), .epo_20ms(epo_20ms), .clr_20ms(clr_20ms),
        .dump(bus), .epoch_cnt(epoch_cnt), .overrun(overrun), .run(run));
    trk_accum_dump #(.ACC_W(8), .SYNC_STAGES(SYNC)) dut8 (
        .mclk(mclk), .mclr(mclr), .if_sample(if_sample), .carr_sin(carr_sin), .carr_cos(carr_cos),
        .code_e(code_e), .code_p(code_p), .code_l(code_l), .enable(enable), .sel_20ms(sel_20ms),
        .len_1ms(len_1ms), .aen_1ms(aen_1ms), .epo_1ms(epo_1ms), .clr_1ms(clr_1ms),
        .len_20ms(len_20ms), .aen_20ms(aen_20ms), .epo_20ms(epo_20ms), .clr_20ms(clr_20ms),
        .dump(bus8), .epoch_cnt(epoch8), .overrun(overrun8), .run(run8));

    always #5 mclk = ~mclk;

    always_comb begin
        d[0] = '{bus.dump_ie, bus.dump_ip, bus.dump_il, bus.dump_qe, bus.dump_qp, bus.dump_ql};
        d[1] = '{bus8.dump_ie, bus8.dump_ip, bus8.dump_il, bus8.dump_qe, bus8.dump_qp, bus8.dump_ql};
    end

    function automatic int fit(int v, int w);
        int lo = -(1 <<< (w - 1));
        int hi = (1 <<< (w - 1)) - 1;
        int span = 1 <<< w;
`ifdef TRK_ACC_SAT_EN
        return v > hi ? hi : v < lo ? lo : v;
`else
        return ((v - lo) % span + span) % span + lo;
`endif
    endfunction

    // one mclk: capture the inputs, clock, apply the channel rules to the model, settle
    task automatic tick();
        bit v[4], f[4], cd[3];
        bit en, a, lat;
        int s, ti, tq, t, sm;
        v = '{sel_20ms ? len_20ms : len_1ms, sel_20ms ? aen_20ms : aen_1ms,
              sel_20ms ? epo_20ms : epo_1ms, sel_20ms ? clr_20ms : clr_1ms};
        s = if_sample[0] ? 3 : 1;
        if (if_sample[1]) s = -s;
        ti = s * (carr_cos[2] ? -int'(carr_cos[1:0]) : int'(carr_cos[1:0]));
        tq = s * (carr_sin[2] ? -int'(carr_sin[1:0]) : int'(carr_sin[1:0]));
        cd = '{code_e, code_p, code_l};
        en = enable;
        a = ack;
        @(posedge mclk);
        if (!mclr) begin
            hist = '{default: 0};
            m_acc = '{default: 0};
            m_dump = '{default: 0};
            m_valid = 0; m_over = 0; m_epoch = 0; m_mode = M_IDLE;
        end else begin
            for (int k = 0; k < 4; k++) begin
                for (int j = SYNC + 1; j > 0; j--) hist[k][j] = hist[k][j-1];
                hist[k][0] = v[k];
                f[k] = hist[k][SYNC] && !hist[k][SYNC+1];
            end
            lat = en && m_mode == M_RUN && f[0];
            if (lat && m_valid && !a) m_over = 1;
            m_valid = lat || (m_valid && !a);
            for (int w = 0; w < 2; w++)
                for (int k = 0; k < 6; k++) begin
                    t = (k < 3 ? ti : tq) * (cd[k % 3] ? 1 : -1);
                    sm = fit(m_acc[w][k] + t, wid[w]);
                    if (lat) m_dump[w][k] = sm;
                    m_acc[w][k] = (!en || m_mode != M_RUN) ? 0 : f[3] ? t : sm;
                end
            if (!en) begin
                m_mode = M_IDLE; m_over = 0; m_epoch = 0;
            end else begin
                if (f[2]) m_epoch = (m_epoch + 1) % 20;
                if (m_mode == M_IDLE) m_mode = M_ARMED;
                else if (m_mode == M_ARMED && f[1]) m_mode = M_RUN;
            end
        end
        #1;
    endtask

    task automatic zero_inputs();
        {if_sample, carr_sin, carr_cos, code_e, code_p, code_l, enable, sel_20ms} = '0;
        {len_1ms, aen_1ms, epo_1ms, clr_1ms, len_20ms, aen_20ms, epo_20ms, clr_20ms} = '0;
        ack = 0;
    endtask

    task automatic rand_inputs();
        if_sample = 2'($urandom);
        carr_sin = 3'($urandom);
        carr_cos = 3'($urandom);
        {code_e, code_p, code_l} = 3'($urandom);
        {len_1ms, aen_1ms, epo_1ms, clr_1ms} = {4{$urandom_range(0, 5) == 0}} & 4'($urandom);
        {len_20ms, aen_20ms, epo_20ms, clr_20ms} = {4{$urandom_range(0, 5) == 0}} & 4'($urandom);
        ack = $urandom_range(0, 3) == 0;
        if ($urandom_range(0, 30) == 0) sel_20ms = ~sel_20ms;
    endtask

    // clr opens a window, len closes it so the dump covers exactly n samples; returns after the dump edge
    task automatic window(int n);
        clr_1ms = 1; tick(); clr_1ms = 0;
        repeat (n - 2) tick();
        len_1ms = 1; tick(); len_1ms = 0;
        repeat (SYNC) tick();
    endtask

    task automatic arm();
        aen_1ms = 1; tick(); aen_1ms = 0;
        repeat (SYNC) tick();
    endtask

    task automatic test_reset();
        mclr = 0;
        repeat (6) begin
            rand_inputs(); enable = 1'($urandom);
            tick();
        end
        checks += 4;
        if (run !== 0) begin failures++; $display("FAIL reset_run: got %0b want 0", run); end
        if (bus.dump_valid !== 0) begin failures++; $display("FAIL reset_valid: got %0b want 0", bus.dump_valid); end
        if (overrun !== 0) begin failures++; $display("FAIL reset_overrun: got %0b want 0", overrun); end
        if (epoch_cnt !== 0) begin failures++; $display("FAIL reset_epoch: got %0d want 0", epoch_cnt); end
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (d[0][k] !== 0) begin failures++; $display("FAIL reset_dump%0d: got %0d want 0", k, d[0][k]); end
        end
        zero_inputs();
        mclr = 1; enable = 1;
        repeat (2) tick();
        aen_1ms = 1; tick(); aen_1ms = 0;
        tick();
        checks++;
        if (run !== 0) begin failures++; $display("FAIL run_early: got %0b want 0 at 2 clocks", run); end
        tick();
        checks++;
        if (run !== 1) begin failures++; $display("FAIL run_latency: got %0b want 1 at 3 clocks", run); end
    endtask

    task automatic test_const();
        if_sample = 2'b01; carr_cos = 3'b010; carr_sin = 3'b101;
        {code_e, code_p, code_l} = 3'b111;
        window(100);
        checks += 4;
        if (bus.dump_valid !== 1) begin failures++; $display("FAIL const_valid: got %0b want 1", bus.dump_valid); end
        if (d[0][1] !== 600) begin failures++; $display("FAIL const_ip: got %0d want 600", d[0][1]); end
        if (d[0][4] !== -300) begin failures++; $display("FAIL const_qp: got %0d want -300", d[0][4]); end
        if (d[0][0] !== 600) begin failures++; $display("FAIL const_ie: got %0d want 600", d[0][0]); end
        ack = 1; tick(); ack = 0;
        code_e = 0;
        window(100);
        checks += 3;
        if (d[0][0] !== -600) begin failures++; $display("FAIL const_ie_neg: got %0d want -600", d[0][0]); end
        if (d[0][3] !== 300) begin failures++; $display("FAIL const_qe_neg: got %0d want 300", d[0][3]); end
        if (overrun !== 0) begin failures++; $display("FAIL const_overrun: got %0b want 0", overrun); end
        ack = 1; tick(); ack = 0;
        code_e = 1;
    endtask

    task automatic test_len_clr();
        if_sample = 2'b01; carr_cos = 3'b010; carr_sin = 3'b000;
        clr_1ms = 1; tick(); clr_1ms = 0;
        repeat (48) tick();
        len_1ms = 1; clr_1ms = 1; tick(); len_1ms = 0; clr_1ms = 0;
        repeat (SYNC) tick();
        checks++;
        if (d[0][1] !== 300) begin failures++; $display("FAIL lenclr_first: got %0d want 300", d[0][1]); end
        ack = 1; tick(); ack = 0;
        repeat (5) tick();
        len_1ms = 1; tick(); len_1ms = 0;
        repeat (SYNC) tick();
        checks++;
        if (d[0][1] !== 60) begin failures++; $display("FAIL lenclr_restart: got %0d want 60", d[0][1]); end
        ack = 1; tick(); ack = 0;
    endtask

    task automatic test_handshake();
        if_sample = 2'b01; carr_cos = 3'b010; carr_sin = 3'b000;
        window(10);
        checks += 2;
        if (bus.dump_valid !== 1) begin failures++; $display("FAIL hs_valid: got %0b want 1", bus.dump_valid); end
        if (overrun !== 0) begin failures++; $display("FAIL hs_no_overrun: got %0b want 0", overrun); end
        window(20);
        checks += 2;
        if (overrun !== 1) begin failures++; $display("FAIL hs_overrun: got %0b want 1", overrun); end
        if (d[0][1] !== 120) begin failures++; $display("FAIL hs_second_snapshot: got %0d want 120", d[0][1]); end
        ack = 1; tick(); ack = 0;
        checks++;
        if (bus.dump_valid !== 0) begin failures++; $display("FAIL hs_ack_clears: got %0b want 0", bus.dump_valid); end
        repeat (3) tick();
        checks++;
        if (overrun !== 1) begin failures++; $display("FAIL hs_overrun_sticky: got %0b want 1", overrun); end
        enable = 0; tick();
        checks += 3;
        if (overrun !== 0) begin failures++; $display("FAIL hs_overrun_clear: got %0b want 0", overrun); end
        if (run !== 0) begin failures++; $display("FAIL hs_idle_run: got %0b want 0", run); end
        if (d[0][1] !== 120) begin failures++; $display("FAIL hs_dump_kept: got %0d want 120", d[0][1]); end
        enable = 1; tick();
        arm();
        window(10);
        clr_1ms = 1; tick(); clr_1ms = 0;
        repeat (13) tick();
        len_1ms = 1; tick(); len_1ms = 0;
        tick();
        ack = 1; tick(); ack = 0;
        checks += 3;
        if (bus.dump_valid !== 1) begin failures++; $display("FAIL hs_ack_len_valid: got %0b want 1", bus.dump_valid); end
        if (overrun !== 0) begin failures++; $display("FAIL hs_ack_len_overrun: got %0b want 0", overrun); end
        if (d[0][1] !== 90) begin failures++; $display("FAIL hs_ack_len_dump: got %0d want 90", d[0][1]); end
        ack = 1; tick(); ack = 0;
    endtask

    task automatic test_overflow();
        if_sample = 2'b01; carr_cos = 3'b011; carr_sin = 3'b000;
        window(20);
        checks += 2;
        if (d[0][1] !== 180) begin failures++; $display("FAIL ovf_wide: got %0d want 180", d[0][1]); end
        if (d[1][1] !== OVF8) begin failures++; $display("FAIL ovf_narrow: got %0d want %0d", d[1][1], OVF8); end
        ack = 1; tick(); ack = 0;
    endtask

    task automatic test_epoch();
        enable = 0; tick();
        enable = 1; tick();
        sel_20ms = 0;
        repeat (25) begin
            epo_1ms = 1; tick(); epo_1ms = 0; tick();
        end
        repeat (SYNC) tick();
        checks++;
        if (epoch_cnt !== 5) begin failures++; $display("FAIL epoch_wrap: got %0d want 5", epoch_cnt); end
        sel_20ms = 1;
        repeat (3) begin
            epo_1ms = 1; aen_1ms = 1; tick(); epo_1ms = 0; aen_1ms = 0; tick();
        end
        repeat (2) begin
            epo_20ms = 1; tick(); epo_20ms = 0; tick();
        end
        repeat (SYNC) tick();
        checks += 2;
        if (epoch_cnt !== 7) begin failures++; $display("FAIL epoch_sel20: got %0d want 7", epoch_cnt); end
        if (run !== 0) begin failures++; $display("FAIL sel20_ignores_1ms_aen: got %0b want 0", run); end
        aen_20ms = 1; tick(); aen_20ms = 0;
        repeat (SYNC) tick();
        checks++;
        if (run !== 1) begin failures++; $display("FAIL sel20_aen: got %0b want 1", run); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            rand_inputs();
            enable = $urandom_range(0, 150) != 0;
            tick();
            checks += 5;
            if (run !== (m_mode == M_RUN)) begin failures++; $display("FAIL rnd_run@%0d: got %0b want %0b", i, run, m_mode == M_RUN); end
            if (bus.dump_valid !== m_valid) begin failures++; $display("FAIL rnd_valid@%0d: got %0b want %0b", i, bus.dump_valid, m_valid); end
            if (overrun !== m_over) begin failures++; $display("FAIL rnd_overrun@%0d: got %0b want %0b", i, overrun, m_over); end
            if (epoch_cnt !== 5'(m_epoch)) begin failures++; $display("FAIL rnd_epoch@%0d: got %0d want %0d", i, epoch_cnt, m_epoch); end
            if (overrun8 !== overrun) begin failures++; $display("FAIL rnd_overrun8@%0d: got %0b want %0b", i, overrun8, overrun); end
            for (int w = 0; w < 2; w++)
                for (int k = 0; k < 6; k++) begin
                    checks++;
                    if (d[w][k] !== m_dump[w][k]) begin
                        failures++;
                        $display("FAIL rnd_dump w%0d k%0d @%0d: got %0d want %0d", wid[w], k, i, d[w][k], m_dump[w][k]);
                    end
                end
        end
    endtask

    initial begin
        zero_inputs();
        test_reset();
        test_const();
        test_len_clr();
        test_handshake();
        test_overflow();
        test_epoch();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
